// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked sequential ALU with iterative shifts and optional shift-add multiply
//
// Optional feature macro: ALU_SEQ_MUL_EN (enables opcode 12, unsigned multiply).
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   in_valid/in_ready     request handshake; in_ready is high only in IDLE
//   opcode, in1, in2, d   operation code, Rd operand, Rs operand, shift amount
//   out_valid/out_ready   result handshake; result and flags are held until taken
//   out, S, Z, C, V       registered result and flags
//   halted                sticky, set once a HLT result has been delivered

module alu_seq #(
  parameter int WIDTH = 16,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [SHW-1:0]   d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             S,
  output logic             Z,
  output logic             C,
  output logic             V,
  output logic             halted
);

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4, OP_CMP = 4'd5, OP_MOV = 4'd6, OP_SLL = 4'd8;
  localparam logic [3:0] OP_ROL = 4'd9, OP_SRL = 4'd10, OP_SRA = 4'd11, OP_MUL = 4'd12;
  localparam logic [3:0] OP_HLT = 4'd15;
  localparam logic [SHW:0] CNT_ONE = (SHW+1)'(1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE, HALT} state_t;
  state_t state, state_nx;

  logic [3:0]       op_q;
  logic [WIDTH-1:0] acc;      // shift operand, or low half / multiplier for MUL
  logic [SHW:0]     cnt;      // one extra bit so WIDTH iterations fit

  logic             accept, is_shift, is_mul, iter, last_step;
  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] imm_res, imm_fv, step_acc, fin_res, fin_fv;
  logic             imm_c, imm_v, imm_fen, step_c, fin_c, fin_v, fin_fen, load;

`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0] hi, mcand;
  logic [WIDTH:0]   msum;
  logic [WIDTH-1:0] step_hi;
`endif

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    accept    = in_ready & in_valid;
    is_shift  = (opcode == OP_SLL) || (opcode == OP_ROL) ||
                (opcode == OP_SRL) || (opcode == OP_SRA);
`ifdef ALU_SEQ_MUL_EN
    is_mul    = (opcode == OP_MUL);
`else
    is_mul    = 1'b0;
`endif
    iter      = (is_shift && (d != '0)) || is_mul;
    last_step = (state == BUSY) && (cnt == CNT_ONE);
  end

  // Single-cycle datapath, evaluated on the raw inputs at accept time.
  always_comb begin
    sum     = {1'b0, in1} + {1'b0, in2};
    diff    = {1'b0, in1} - {1'b0, in2};
    imm_res = '0;
    imm_c   = 1'b0;
    imm_v   = 1'b0;
    imm_fen = 1'b1;
    case (opcode)
      OP_ADD: begin
        imm_res = sum[WIDTH-1:0];
        imm_c   = sum[WIDTH];
        imm_v   = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        imm_res = (opcode == OP_SUB) ? diff[WIDTH-1:0] : '0;
        imm_c   = diff[WIDTH];
        imm_v   = (in1[WIDTH-1] != in2[WIDTH-1]) && (diff[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_AND: imm_res = in1 & in2;
      OP_OR:  imm_res = in1 | in2;
      OP_XOR: imm_res = in1 ^ in2;
      OP_MOV, OP_SLL, OP_ROL, OP_SRL, OP_SRA: imm_res = in2;  // shifts here only when d=0
      default: imm_fen = 1'b0;  // undefined opcodes and HLT: result and all flags zero
    endcase
    // CMP discards the difference but still derives S/Z from it
    imm_fv = (opcode == OP_CMP) ? diff[WIDTH-1:0] : imm_res;
  end

  // One iteration of the multi-cycle operation held in op_q.
  always_comb begin
    step_acc = acc;
    step_c   = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    msum     = '0;
    step_hi  = hi;
`endif
    case (op_q)
      OP_SLL: begin step_acc = {acc[WIDTH-2:0], 1'b0};         step_c = acc[WIDTH-1]; end
      OP_ROL:       step_acc = {acc[WIDTH-2:0], acc[WIDTH-1]};
      OP_SRL: begin step_acc = {1'b0, acc[WIDTH-1:1]};         step_c = acc[0]; end
      OP_SRA: begin step_acc = {acc[WIDTH-1], acc[WIDTH-1:1]}; step_c = acc[0]; end
`ifdef ALU_SEQ_MUL_EN
      // Right-shifting multiplier: add the multiplicand into the high half when
      // the current multiplier bit is set, then shift {hi, acc} right by one.
      OP_MUL: begin
        msum     = {1'b0, hi} + (acc[0] ? {1'b0, mcand} : '0);
        step_hi  = msum[WIDTH:1];
        step_acc = {msum[0], acc[WIDTH-1:1]};
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    load    = 1'b0;
    fin_res = '0;
    fin_fv  = '0;
    fin_c   = 1'b0;
    fin_v   = 1'b0;
    fin_fen = 1'b0;
    if (accept && !iter) begin
      load    = 1'b1;
      fin_res = imm_res;
      fin_fv  = imm_fv;
      fin_c   = imm_c;
      fin_v   = imm_v;
      fin_fen = imm_fen;
    end else if (last_step) begin
      load    = 1'b1;
      fin_res = step_acc;
      fin_fv  = step_acc;
      fin_c   = step_c;  // the bit shifted out on the final iteration
      fin_fen = 1'b1;
`ifdef ALU_SEQ_MUL_EN
      if (op_q == OP_MUL) begin
        fin_c = |step_hi;
        fin_v = |step_hi;
      end
`endif
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (in_valid) state_nx = iter ? BUSY : DONE;
      BUSY: if (cnt == CNT_ONE) state_nx = DONE;
      DONE: if (out_ready) state_nx = (op_q == OP_HLT) ? HALT : IDLE;
      HALT: state_nx = HALT;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= '0;
      acc    <= '0;
      cnt    <= '0;
      out    <= '0;
      S      <= 1'b0;
      Z      <= 1'b0;
      C      <= 1'b0;
      V      <= 1'b0;
      halted <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      hi     <= '0;
      mcand  <= '0;
`endif
    end else begin
      if (accept) begin
        op_q <= opcode;
        acc  <= in2;
        cnt  <= is_mul ? (SHW+1)'(WIDTH) : {1'b0, d};
`ifdef ALU_SEQ_MUL_EN
        hi    <= '0;
        mcand <= in1;
`endif
      end else if (state == BUSY) begin
        acc <= step_acc;
        cnt <= cnt - CNT_ONE;
`ifdef ALU_SEQ_MUL_EN
        hi  <= step_hi;
`endif
      end
      if (load) begin
        out <= fin_res;
        S   <= fin_fen & fin_fv[WIDTH-1];
        Z   <= fin_fen & ~|fin_fv;
        C   <= fin_c;
        V   <= fin_v;
      end
      if ((state == DONE) && out_ready && (op_q == OP_HLT)) halted <= 1'b1;
    end
  end

endmodule
